// File: rtl/lap_timer_pkg.sv
// Shared constants for the lap timer: FSM state encodings, command codes
// and the helper that resolves simultaneous commands into one.
package lap_timer_pkg;

    // FSM state encodings (visible on the state output)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_STOPPED = 2'd3;

    // Resolved command codes; a larger code wins when several are raised
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_PAUSE = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    // Collapse the three level inputs to the single highest-priority command
    function automatic logic [1:0] decode_cmd(input logic start,
                                              input logic pause,
                                              input logic stop);
        logic [1:0] cmd;
        cmd = CMD_NONE;
        if (stop) begin
            cmd = CMD_STOP;
        end else if (pause) begin
            cmd = CMD_PAUSE;
        end else if (start) begin
            cmd = CMD_START;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/lap_mem.sv
// Lap storage: synchronous one-write/one-read RAM. The read register samples
// the array before the write lands, so a same-address access returns the old
// word. Contents are never reset; the owner masks unwritten entries.
module lap_mem
    import lap_timer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TICK_W = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [TICK_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [TICK_W-1:0] rd_data
);

    logic [TICK_W-1:0] mem_q [DEPTH];
    logic [TICK_W-1:0] rd_data_q;

    // Write port and registered read port (read-before-write on collision)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lap_timer.sv
// Lap timer: prescaled unit counter with an IDLE/RUN/PAUSED/STOPPED FSM.
// Each RUN->PAUSED transition records the current unit count in lap memory;
// laps can be read back in any state with a one-cycle latency.
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int TICK_W  = 8,
    parameter int DEPTH   = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic              tick,
    output logic [TICK_W-1:0] unit_count,
    output logic [1:0]        state,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [TICK_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   lap_count,
    output logic              full,
    output logic              overflow
);

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int LAP_W = ADDR_W + 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
    localparam logic [LAP_W-1:0] LAP_FULL = LAP_W'(DEPTH);

    logic [1:0]        state_q,     state_d;
    logic [PRE_W-1:0]  pre_q,       pre_d;
    logic [TICK_W-1:0] unit_q,      unit_d;
    logic              tick_q,      tick_d;
    logic [LAP_W-1:0]  lap_count_q, lap_count_d;
    logic              overflow_q,  overflow_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              rd_hit_q,    rd_hit_d;

    logic [1:0]        cmd;
    logic              full_now;
    logic              wr_en;
    logic [TICK_W-1:0] mem_rd_data;

    assign full_now = (lap_count_q == LAP_FULL);

    // Next-state, counter and lap-write decisions from the resolved command
    always_comb begin
        cmd         = decode_cmd(start, pause, stop);
        state_d     = state_q;
        pre_d       = pre_q;
        unit_d      = unit_q;
        tick_d      = 1'b0;
        lap_count_d = lap_count_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd == CMD_START) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd == CMD_STOP) begin
                    state_d = ST_STOPPED;
                end else if (cmd == CMD_PAUSE) begin
                    // Lap capture happens only on this transition, so a held
                    // pause cannot record twice.
                    state_d = ST_PAUSED;
                    if (full_now) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        lap_count_d = lap_count_q + LAP_W'(1);
                    end
                end else begin
                    // Counting only while staying in RUN; leaving edges hold
                    if (pre_q == PRE_MAX) begin
                        pre_d  = '0;
                        unit_d = unit_q + TICK_W'(1);
                        tick_d = 1'b1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            ST_PAUSED: begin
                if (cmd == CMD_STOP) begin
                    state_d = ST_STOPPED;
                end else if (cmd == CMD_START) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // STOPPED: a restart begins a fresh session, memory kept
                if (cmd == CMD_START) begin
                    state_d     = ST_RUN;
                    pre_d       = '0;
                    unit_d      = '0;
                    lap_count_d = '0;
                    overflow_d  = 1'b0;
                end
            end
        endcase
    end

    // Read request pipeline: valid and in-range flag line up with RAM output
    always_comb begin
        rd_valid_d = rd_en;
        rd_hit_d   = rd_en && ({1'b0, rd_addr} < lap_count_q);
    end

    // Control and status registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            unit_q      <= '0;
            tick_q      <= 1'b0;
            lap_count_q <= '0;
            overflow_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            unit_q      <= unit_d;
            tick_q      <= tick_d;
            lap_count_q <= lap_count_d;
            overflow_q  <= overflow_d;
            rd_valid_q  <= rd_valid_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    lap_mem #(
        .DEPTH  (DEPTH),
        .TICK_W (TICK_W)
    ) u_lap_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (lap_count_q[ADDR_W-1:0]),
        .wr_data (unit_q),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_rd_data)
    );

    assign tick       = tick_q;
    assign unit_count = unit_q;
    assign state      = state_q;
    assign lap_count  = lap_count_q;
    assign full       = full_now;
    assign overflow   = overflow_q;
    assign rd_valid   = rd_valid_q;
    // Unwritten or out-of-session entries read as zero; RAM needs no reset
    assign rd_data    = rd_hit_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer (CLK_DIV=4, TICK_W=4, DEPTH=4): directed scenarios
// with constant expectations, then randomized commands checked against a
// cycle-level reference model of the timer's rules.
module tb_lap_timer;

    localparam int CLK_DIV = 4;
    localparam int TICK_W  = 4;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              tick;
    logic [TICK_W-1:0] unit_count;
    logic [1:0]        state;
    logic [TICK_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   lap_count;
    logic              full;
    logic              overflow;

    lap_timer #(
        .CLK_DIV (CLK_DIV),
        .TICK_W  (TICK_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .tick       (tick),
        .unit_count (unit_count),
        .state      (state),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .lap_count  (lap_count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    // Units are derived from the number of cycles spent counting in RUN.
    int m_state;
    int m_run_cyc;
    int m_tick;
    int m_laps [DEPTH];
    int m_lap_cnt;
    int m_ovf;
    int m_rdv;
    int m_rdd;

    function automatic int m_unit();
        return (m_run_cyc / CLK_DIV) % (1 << TICK_W);
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_run_cyc = 0;
        m_tick    = 0;
        m_lap_cnt = 0;
        m_ovf     = 0;
        m_rdv     = 0;
        m_rdd     = 0;
    endtask

    task automatic model_advance();
        m_run_cyc++;
        if (m_run_cyc % CLK_DIV == 0) m_tick = 1;
    endtask

    task automatic model_edge();
        if (rd_en) begin
            m_rdv = 1;
            m_rdd = (int'(rd_addr) < m_lap_cnt) ? m_laps[rd_addr] : 0;
        end else begin
            m_rdv = 0;
            m_rdd = 0;
        end
        m_tick = 0;
        if (stop) begin
            if (m_state == 1 || m_state == 2) m_state = 3;
        end else if (pause) begin
            if (m_state == 1) begin
                m_state = 2;
                if (m_lap_cnt < DEPTH) begin
                    m_laps[m_lap_cnt] = m_unit();
                    m_lap_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
        end else if (start) begin
            case (m_state)
                0, 2: m_state = 1;
                3: begin
                    m_state   = 1;
                    m_run_cyc = 0;
                    m_lap_cnt = 0;
                    m_ovf     = 0;
                end
                default: model_advance();
            endcase
        end else if (m_state == 1) begin
            model_advance();
        end
    endtask

    // One clock edge: model follows the same inputs, then sample 1 ns later
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (int'(unit_count) == target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", state); end
        tests_run++; if (unit_count !== '0) begin tests_failed++; $display("FAIL reset_unit got %0d want 0", unit_count); end
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got %0d want 0", tick); end
        tests_run++; if (lap_count !== '0) begin tests_failed++; $display("FAIL reset_lap_count got %0d want 0", lap_count); end
        tests_run++; if (full !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got full=%0d ovf=%0d want 0/0", full, overflow); end
        tests_run++; if (rd_valid !== 1'b0 || rd_data !== '0) begin tests_failed++; $display("FAIL reset_read got v=%0d d=%0d want 0/0", rd_valid, rd_data); end
        rst = 1'b1;
        step();
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL idle_hold got %0d want 0", state); end
    endtask

    task automatic test_run_ticks();
        int  ticks;
        bit  wide;
        bit  prev;
        ticks = 0; wide = 0; prev = 0;
        start = 1'b1; step(); start = 1'b0;
        tests_run++; if (state !== 2'd1) begin tests_failed++; $display("FAIL start_run got %0d want 1", state); end
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick === 1'b1) begin
                ticks++;
                if (prev) wide = 1;
            end
            prev = (tick === 1'b1);
        end
        $display("[TB] run 40 cycles: ticks=%0d unit=%0d", ticks, unit_count);
        tests_run++; if (ticks != 10) begin tests_failed++; $display("FAIL tick_count got %0d want 10", ticks); end
        tests_run++; if (wide) begin tests_failed++; $display("FAIL tick_width got wide=1 want 0"); end
        tests_run++; if (unit_count !== 4'd10) begin tests_failed++; $display("FAIL unit_after_40 got %0d want 10", unit_count); end
    endtask

    task automatic test_wrap();
        bit ok;
        run_until(15, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrap_reach15 got %0d want 15", unit_count); end
        repeat (CLK_DIV) step();
        tests_run++; if (unit_count !== 4'd0) begin tests_failed++; $display("FAIL wrap_unit got %0d want 0", unit_count); end
        tests_run++; if (tick !== 1'b1) begin tests_failed++; $display("FAIL wrap_tick got %0d want 1", tick); end
    endtask

    task automatic test_laps();
        int targets [3] = '{2, 5, 7};
        int exp_rd  [4] = '{2, 5, 7, 0};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            run_until(targets[k], ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL lap_reach got %0d want %0d", unit_count, targets[k]); end
            pause = 1'b1; step(); step(); pause = 1'b0;
            tests_run++; if (state !== 2'd2) begin tests_failed++; $display("FAIL lap_paused got %0d want 2", state); end
            if (k < 2) begin
                start = 1'b1; step(); start = 1'b0;
            end
        end
        tests_run++; if (lap_count !== 3'd3) begin tests_failed++; $display("FAIL lap_count3 got %0d want 3", lap_count); end
        for (int a = 0; a < 4; a++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(a); step(); rd_en = 1'b0;
            $display("[TB] read addr=%0d valid=%0d data=%0d", a, rd_valid, rd_data);
            tests_run++; if (rd_valid !== 1'b1 || int'(rd_data) != exp_rd[a]) begin tests_failed++; $display("FAIL lap_read addr=%0d got v=%0d d=%0d want v=1 d=%0d", a, rd_valid, rd_data, exp_rd[a]); end
            step();
            tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL lap_read_idle got %0d want 0", rd_valid); end
        end
    endtask

    task automatic test_full_overflow();
        bit ok;
        start = 1'b1; step(); start = 1'b0;
        run_until(8, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL full_reach got %0d want 8", unit_count); end
        pause = 1'b1; step(); pause = 1'b0;
        tests_run++; if (full !== 1'b1 || lap_count !== 3'd4) begin tests_failed++; $display("FAIL full_set got full=%0d lap=%0d want 1/4", full, lap_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_early got %0d want 0", overflow); end
        start = 1'b1; step(); start = 1'b0;
        run_until(9, ok);
        pause = 1'b1; step(); pause = 1'b0;
        tests_run++; if (overflow !== 1'b1 || state !== 2'd2) begin tests_failed++; $display("FAIL ovf_set got ovf=%0d st=%0d want 1/2", overflow, state); end
        tests_run++; if (lap_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_lap got %0d want 4", lap_count); end
        rd_en = 1'b1; rd_addr = 2'd3; step(); rd_en = 1'b0;
        tests_run++; if (rd_data !== 4'd8 || rd_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_addr3 got d=%0d v=%0d want 8/1", rd_data, rd_valid); end
    endtask

    task automatic test_priority();
        bit ok;
        start = 1'b1; step();
        pause = 1'b1; stop = 1'b1; step();
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        tests_run++; if (state !== 2'd3) begin tests_failed++; $display("FAIL prio_stop got %0d want 3", state); end
        start = 1'b1; step(); start = 1'b0;
        tests_run++; if (state !== 2'd1 || unit_count !== '0) begin tests_failed++; $display("FAIL restart got st=%0d unit=%0d want 1/0", state, unit_count); end
        tests_run++; if (lap_count !== '0 || overflow !== 1'b0 || full !== 1'b0) begin tests_failed++; $display("FAIL restart_clear got lap=%0d ovf=%0d full=%0d want 0/0/0", lap_count, overflow, full); end
        run_until(1, ok);
        start = 1'b1; pause = 1'b1; stop = 1'b1; step();
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        tests_run++; if (state !== 2'd3 || lap_count !== '0) begin tests_failed++; $display("FAIL prio_nowrite got st=%0d lap=%0d want 3/0", state, lap_count); end
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset_mid();
        repeat (6) step();
        rd_en = 1'b1; rd_addr = 2'd0;
        rst = 1'b0;
        #2;
        model_reset();
        tests_run++; if (state !== 2'd0 || unit_count !== '0 || tick !== 1'b0) begin tests_failed++; $display("FAIL midrst_ctl got st=%0d unit=%0d tick=%0d want 0/0/0", state, unit_count, tick); end
        tests_run++; if (lap_count !== '0 || full !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL midrst_laps got lap=%0d full=%0d ovf=%0d want 0/0/0", lap_count, full, overflow); end
        tests_run++; if (rd_valid !== 1'b0 || rd_data !== '0) begin tests_failed++; $display("FAIL midrst_read got v=%0d d=%0d want 0/0", rd_valid, rd_data); end
        @(posedge clk);
        #1;
        rst = 1'b1; rd_en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            pause   = ($urandom_range(0, 9) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            rd_en   = $urandom_range(0, 1);
            rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            step();
            tests_run++; if (int'(state) != m_state) begin tests_failed++; $display("FAIL rnd_state cyc=%0d got %0d want %0d", i, state, m_state); end
            tests_run++; if (int'(unit_count) != m_unit()) begin tests_failed++; $display("FAIL rnd_unit cyc=%0d got %0d want %0d", i, unit_count, m_unit()); end
            tests_run++; if (int'(tick) != m_tick) begin tests_failed++; $display("FAIL rnd_tick cyc=%0d got %0d want %0d", i, tick, m_tick); end
            tests_run++; if (int'(lap_count) != m_lap_cnt) begin tests_failed++; $display("FAIL rnd_lap cyc=%0d got %0d want %0d", i, lap_count, m_lap_cnt); end
            tests_run++; if (int'(full) != int'(m_lap_cnt == DEPTH)) begin tests_failed++; $display("FAIL rnd_full cyc=%0d got %0d want %0d", i, full, m_lap_cnt == DEPTH); end
            tests_run++; if (int'(overflow) != m_ovf) begin tests_failed++; $display("FAIL rnd_ovf cyc=%0d got %0d want %0d", i, overflow, m_ovf); end
            tests_run++; if (int'(rd_valid) != m_rdv) begin tests_failed++; $display("FAIL rnd_rdv cyc=%0d got %0d want %0d", i, rd_valid, m_rdv); end
            tests_run++; if (int'(rd_data) != m_rdd) begin tests_failed++; $display("FAIL rnd_rdd cyc=%0d got %0d want %0d", i, rd_data, m_rdd); end
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_wrap();
        test_laps();
        test_full_overflow();
        test_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
